// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
// The control-vector constants below cover every output pattern the sequencer can drive.
package pipeline_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    MC_BUSY = 1'b1
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctrl_t;

  // Field order: pc, ifid, idex, exmem, memwb enables, then ifid, idex, exmem flushes
  localparam pipe_ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam pipe_ctrl_t CTRL_MC       = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-buffer controls exchanged between the datapath and the sequencer.
// The datapath is the master, the sequencer the slave.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
);

  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_mc_start;
  logic                  branch_taken;
  logic                  mem_ready;

  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_mc_start, branch_taken, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_mc_start, branch_taken, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
// Register 0 is hardwired to zero, so it never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  output logic                  load_use
);

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stage-buffer sequencer: load-use stalls, branch flushes, multi-cycle EX and memory waits.
// Define PIPELINE_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int MC_LATENCY = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_ctrl_if.slave    pif,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_cycles
);

  localparam int MC_CNT_W = $clog2(MC_LATENCY + 1);
  // The start cycle is the first of MC_LATENCY, and the release cycle is the last
  localparam logic [MC_CNT_W-1:0] MC_LOAD = MC_CNT_W'((MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0);

  pipe_state_t         state, state_nxt;
  logic [MC_CNT_W-1:0] mc_cnt, mc_cnt_nxt;
  pipe_ctrl_t          ctrl;
  logic                load_use;

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_mem_read (pif.ex_mem_read),
    .ex_rd       (pif.ex_rd),
    .id_rs1      (pif.id_rs1),
    .id_rs2      (pif.id_rs2),
    .id_uses_rs2 (pif.id_uses_rs2),
    .load_use    (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      mc_cnt <= '0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= mc_cnt_nxt;
    end
  end

  always_comb begin
    ctrl       = CTRL_HOLD;
    state_nxt  = state;
    mc_cnt_nxt = mc_cnt;
    if (rst) begin
      ctrl       = CTRL_HOLD;
      state_nxt  = RUN;
      mc_cnt_nxt = '0;
    end else if (!pif.mem_ready) begin
      ctrl = CTRL_HOLD;
    end else if (state == MC_BUSY) begin
      if (mc_cnt != '0) begin
        ctrl       = CTRL_MC;
        mc_cnt_nxt = mc_cnt - MC_CNT_W'(1);
      end else begin
        ctrl      = CTRL_RUN;
        state_nxt = RUN;
      end
    end else if (pif.branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (pif.ex_mc_start && (MC_LATENCY > 1)) begin
      ctrl       = CTRL_MC;
      mc_cnt_nxt = MC_LOAD;
      state_nxt  = MC_BUSY;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end else begin
      ctrl = CTRL_RUN;
    end
  end

  assign pif.pc_en       = ctrl.pc_en;
  assign pif.ifid_en     = ctrl.ifid_en;
  assign pif.idex_en     = ctrl.idex_en;
  assign pif.exmem_en    = ctrl.exmem_en;
  assign pif.memwb_en    = ctrl.memwb_en;
  assign pif.ifid_flush  = ctrl.ifid_flush;
  assign pif.idex_flush  = ctrl.idex_flush;
  assign pif.exmem_flush = ctrl.exmem_flush;

`ifdef PIPELINE_PERF_CNT_EN
  logic any_flush;
  assign any_flush = ctrl.ifid_flush | ctrl.idex_flush | ctrl.exmem_flush;

  // Freeze cycles count as stalls since the PC is held; both counters stick at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      if (!ctrl.pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + PERF_W'(1);
      if (any_flush && (flush_cycles != '1))
        flush_cycles <= flush_cycles + PERF_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected controls, a monitor checks them.
// Counter expectations follow PIPELINE_PERF_CNT_EN (zero when the macro is undefined).
module tb_pipeline_ctrl;

  localparam int RW = 4;
  localparam int PW = 16;

  // Expected control vectors: {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
  localparam logic [7:0] E_HOLD = 8'b00000_000;
  localparam logic [7:0] E_RUN  = 8'b11111_000;
  localparam logic [7:0] E_MC   = 8'b00011_001;
  localparam logic [7:0] E_BR   = 8'b11111_110;
  localparam logic [7:0] E_LU   = 8'b00111_010;

  typedef struct {
    string      name;
    logic [7:0] ctrl;
    bit         chk_cnt;
    int         stall;
    int         flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [PW-1:0] stall_cycles, flush_cycles;
  exp_t scoreboard[$];
  int tests  = 0;
  int failed = 0;

  pipeline_ctrl_if #(.REG_ADDR_W(RW)) pif ();

  pipeline_ctrl #(.REG_ADDR_W(RW), .MC_LATENCY(4), .PERF_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pif          (pif),
    .stall_cycles (stall_cycles),
    .flush_cycles (flush_cycles)
  );

  always #5 clk = ~clk;

  function automatic int expc(input int v);
`ifdef PIPELINE_PERF_CNT_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic applyStimulus(input string name, input logic r,
                               input logic [RW-1:0] rs1, input logic [RW-1:0] rs2, input logic u2,
                               input logic [RW-1:0] rd, input logic mrd, input logic mcs,
                               input logic br, input logic rdy, input logic [7:0] exp,
                               input bit chk = 1'b0, input int st = 0, input int fl = 0);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    pif.id_rs1       = rs1;
    pif.id_rs2       = rs2;
    pif.id_uses_rs2  = u2;
    pif.ex_rd        = rd;
    pif.ex_mem_read  = mrd;
    pif.ex_mc_start  = mcs;
    pif.branch_taken = br;
    pif.mem_ready    = rdy;
    e.name    = name;
    e.ctrl    = exp;
    e.chk_cnt = chk;
    e.stall   = expc(st);
    e.flush   = expc(fl);
    scoreboard.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] act;
    act = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
           pif.ifid_flush, pif.idex_flush, pif.exmem_flush};
    tests++;
    if (act !== e.ctrl) begin
      failed++;
      $display("[TB] FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
    end
    if (e.chk_cnt) begin
      tests++;
      if (stall_cycles !== PW'(e.stall) || flush_cycles !== PW'(e.flush)) begin
        failed++;
        $display("[TB] FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                 e.name, stall_cycles, flush_cycles, e.stall, e.flush);
      end
    end
  endtask

  // Monitor: outputs are valid every cycle, so each negedge consumes one pending expectation
  initial begin
    forever begin
      @(negedge clk);
      if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
    end
  end

  initial begin
    int budget;
    rst              = 1'b1;
    pif.id_rs1       = '0;
    pif.id_rs2       = '0;
    pif.id_uses_rs2  = 1'b0;
    pif.ex_rd        = '0;
    pif.ex_mem_read  = 1'b0;
    pif.ex_mc_start  = 1'b1;
    pif.branch_taken = 1'b0;
    pif.mem_ready    = 1'b1;

    //             name             rst rs1 rs2 u2  rd  mrd mcs br  rdy  expected
    applyStimulus("reset_a",        1,  0,  0,  0,  0,  0,  1,  0,  1,   E_HOLD);
    applyStimulus("reset_b",        1,  0,  0,  0,  0,  0,  1,  0,  1,   E_HOLD);
    applyStimulus("after_reset",    0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN, 1, 0, 0);
    applyStimulus("lu_rs2",         0,  1,  5,  1,  5,  1,  0,  0,  1,   E_LU);
    applyStimulus("lu_bubble",      0,  1,  5,  1,  5,  0,  0,  0,  1,   E_RUN, 1, 1, 1);
    applyStimulus("lu_rd_zero",     0,  0,  0,  1,  0,  1,  0,  0,  1,   E_RUN);
    applyStimulus("lu_rs1",         0,  3,  7,  0,  3,  1,  0,  0,  1,   E_LU);
    applyStimulus("lu_rs2_unused",  0,  1,  7,  0,  7,  1,  0,  0,  1,   E_RUN);
    applyStimulus("branch_vs_lu",   0,  1,  5,  1,  5,  1,  0,  1,  1,   E_BR);
    applyStimulus("mc_start",       0,  0,  0,  0,  0,  0,  1,  0,  1,   E_MC);
    applyStimulus("mc_busy_br_ign", 0,  0,  0,  0,  0,  0,  0,  1,  1,   E_MC);
    applyStimulus("mc_busy_mcs_ign",0,  0,  0,  0,  0,  0,  1,  0,  1,   E_MC);
    applyStimulus("mc_release",     0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN, 1, 5, 6);
    applyStimulus("mc_after_run",   0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN);
    applyStimulus("frz_mc_start",   0,  0,  0,  0,  0,  0,  1,  0,  1,   E_MC);
    applyStimulus("frz_mc_busy1",   0,  0,  0,  0,  0,  0,  0,  0,  1,   E_MC);
    applyStimulus("frz_hold_a",     0,  0,  0,  0,  0,  0,  0,  0,  0,   E_HOLD);
    applyStimulus("frz_hold_b",     0,  0,  0,  0,  0,  0,  0,  0,  0,   E_HOLD);
    applyStimulus("frz_mc_busy2",   0,  0,  0,  0,  0,  0,  0,  0,  1,   E_MC);
    applyStimulus("frz_release",    0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN, 1, 10, 9);
    applyStimulus("frz_over_lu",    0,  2,  0,  0,  2,  1,  0,  0,  0,   E_HOLD);
    applyStimulus("frz_over_done",  0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN, 1, 11, 9);
    applyStimulus("br_vs_mc",       0,  0,  0,  0,  0,  0,  1,  1,  1,   E_BR);
    applyStimulus("br_vs_mc_after", 0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN, 1, 11, 10);
    applyStimulus("rst_mid_start",  0,  0,  0,  0,  0,  0,  1,  0,  1,   E_MC);
    applyStimulus("rst_mid",        1,  0,  0,  0,  0,  0,  0,  0,  1,   E_HOLD);
    applyStimulus("rst_mid_after",  0,  0,  0,  0,  0,  0,  0,  0,  1,   E_RUN, 1, 0, 0);

    budget = 0;
    while (scoreboard.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (scoreboard.size() > 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", scoreboard.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the pipeline stage buffers (IF/ID, ID/EX, EX/MEM, MEM/WB). It drives each buffer's enable and bubble-insert (flush) line, plus the PC enable. It resolves load-use hazards, taken branches, multi-cycle EX operations and data-memory wait states. It is the only block that may hold or flush a stage buffer. Flush lines are ORed with `rst` at each buffer's reset input.

## Interface
- `REG_ADDR_W`, 4, register-address width.
- `MC_LATENCY`, 4, total EX occupancy in cycles of a multi-cycle op; legal range is 1 or more.
- `PERF_W`, 16, performance counter width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source registers of the instruction in ID.
- `id_uses_rs2`  in  1  the ID instruction reads rs2.
- `ex_rd`  in  REG_ADDR_W  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_mc_start`  in  1  the EX instruction is multi-cycle.
- `branch_taken`  in  1  taken branch resolved in EX.
- `mem_ready`  in  1  data memory ready; 0 means wait.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1  buffer load enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`  out  1  load a zero bubble at the next edge.
- `stall_cycles`, `flush_cycles`  out  PERF_W  performance counters.

## Operation
- FSM states are RUN and MC_BUSY. A down-counter `mc_cnt` has width $clog2(MC_LATENCY+1).
- Outputs are combinational (Mealy) from state and inputs. State and counter are registered.
- Conditions are evaluated in priority order, highest first:
  1. `rst`=1: all enables 0, flushes 0. Next state is RUN, `mc_cnt`=0, counters cleared. This applies mid-operation too.
  2. `mem_ready`=0 (freeze): all enables 0, flushes 0. State, `mc_cnt` and counters other than `stall_cycles` hold.
  3. MC_BUSY with `mc_cnt`≠0: `pc_en`/`ifid_en`/`idex_en`=0, `exmem_en`=1, `exmem_flush`=1, `memwb_en`=1. `mc_cnt` decrements. `branch_taken` and `ex_mc_start` are ignored.
  4. MC_BUSY with `mc_cnt`=0 (release): all enables 1, flushes 0. Next state is RUN.
  5. RUN with `branch_taken`: all enables 1, `ifid_flush`=`idex_flush`=1. `ex_mc_start` is ignored.
  6. RUN with `ex_mc_start` and MC_LATENCY>1: same outputs as item 3. Load `mc_cnt`=MC_LATENCY-2 and go to MC_BUSY. With MC_LATENCY=1 the op is treated as ordinary.
  7. RUN with load-use hazard: `pc_en`=`ifid_en`=0, `idex_flush`=1, all other enables 1.
     - Hazard condition: `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`==`id_rs1` || (`id_uses_rs2` && `ex_rd`==`id_rs2`)).
  8. Otherwise: all enables 1, flushes 0.
- A flush output is only asserted together with the matching enable at 1.

## Timing
- Zero-cycle decision latency: a hazard present in cycle N gates the edge at the end of cycle N.
- A load-use hazard costs exactly 1 bubble. Stall ends without extra state, because the bubble clears `ex_mem_read`.
- A multi-cycle op holds EX for exactly MC_LATENCY cycles (the start cycle counts as the first). EX/MEM captures the result on the release edge.
- A taken branch costs 2 bubbles (IF/ID and ID/EX).
- A `mem_ready`=0 cycle extends any stall or busy period by exactly one cycle. No counter decrement is lost.
- After the `rst` deassert edge the block is in RUN with all enables 1.

## Configuration
- `PIPELINE_PERF_CNT_EN` defined:
  - `stall_cycles` increments each non-reset cycle with `pc_en`=0, including freeze.
  - `flush_cycles` increments each cycle with any flush asserted.
  - Both saturate at 2^PERF_W−1.
- Undefined: no counter registers are built and both ports are tied to 0.

## Structure
- `pipeline_ctrl_pkg` holds:
  - the `pipe_state_t` enum (RUN, MC_BUSY);
  - the `pipe_ctrl_t` struct bundling the enables and flushes;
  - default `REG_ADDR_W`.
- One sub-module, `hazard_detect`: the combinational load-use comparator.

## Test plan
- Reset: `rst`=1 for 2 cycles with `ex_mc_start`=1 → all enables 0. After release, RUN with all enables 1 and counters 0.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → exactly one cycle of `pc_en`=0, `idex_flush`=1. With `ex_rd`=0 → no stall.
- Multi-cycle: MC_LATENCY=4, `ex_mc_start` pulse → `exmem_flush`=1 and front stalled for 3 cycles. 4th cycle has all enables 1, then RUN.
- Freeze during busy: `mem_ready`=0 for 2 cycles inside an MC_LATENCY=4 op → release occurs 6 cycles after start. Enables are 0 during the freeze.
- Branch versus load-use in the same cycle: `branch_taken`=1 plus hazard → `ifid_flush`=`idex_flush`=1 and `pc_en`=1.
- Counters (macro on): one load-use, one branch and one 4-cycle op → `stall_cycles`=4, `flush_cycles`=5. With the macro off, both read 0.
